hazard_fwd_unit: RTL and testbench
==================================

# hazard_fwd_unit

Pipeline hazard and forwarding controller for the 5-stage MIPS-32 datapath. It tracks the destination register of each instruction as it moves ID→EX→MEM→WB, and drives the 2-bit select of the two EX-stage operand MUX32_3to1 instances that feed the ALU. It also raises a load-use stall toward the PC and IF/ID registers. It sits directly upstream of the ALU operand muxes.

## Interface
Parameters:
- REG_W, 5, register-specifier width (32 GPRs)
- SEL_W, 2, forwarding-select width, matching the 3-to-1 mux sel

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all stage state
- id_rs  in  REG_W  rs field of the instruction in ID
- id_rt  in  REG_W  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_dst  in  REG_W  destination of the ID instruction (after RegDst selection)
- id_regwrite  in  1  ID instruction writes the register file
- id_memread  in  1  ID instruction is a load
- flush  in  1  kill the ID instruction (taken branch/jump)
- stall  out  1  hold PC and IF/ID; combinational
- fwd_a  out  SEL_W  EX operand A mux select
- fwd_b  out  SEL_W  EX operand B mux select

## Operation
- Internal stage records:
  - EX: rs, rt, dst, regwrite, memread
  - MEM: dst, regwrite, memread
  - WB: dst, regwrite
- Bubble: regwrite=0, memread=0, dst=0, rs=0, rt=0.
- Each rising edge: WB←MEM, MEM←EX.
- EX←ID fields, unless stall or flush is active; in that case EX←bubble.
- Load-use hazard:
  - Condition: EX.memread and EX.regwrite and EX.dst≠0, and either (id_use_rs and id_rs==EX.dst) or (id_use_rt and id_rt==EX.dst).
  - stall = hazard and not flush. A flush kills the instruction, so no stall is needed.
- Forwarding select for fwd_a, with EX.rs as source; fwd_b is identical using EX.rt:
  - 2'd1 (EX/MEM ALU result) if MEM.regwrite and MEM.dst≠0 and MEM.dst==src.
  - Else 2'd2 (MEM/WB result) if WB.regwrite and WB.dst≠0 and WB.dst==src.
  - Else 2'd0 (ID/EX register-file value).
  - EX/MEM always has priority over MEM/WB, so the newest value wins.
- Register $0 is never forwarded and never causes a stall.
- A load in MEM never matches a dependent in EX: the stall guarantees one bubble between them, so the load result arrives via MEM/WB (sel 2).
- ID-read/WB-write in the same cycle is resolved by the write-first register file, not by this block.
- 2'd3 is never driven.

## Timing
- Reset asserted, asynchronously: all records become bubbles.
  - Outputs: stall=0, fwd_a=2'd0, fwd_b=2'd0.
  - These outputs hold until the first post-reset edge.
- Reset mid-operation discards all in-flight records; no stale forwarding after release.
- Latency:
  - An ID instruction issued at edge n is in EX during cycle n+1, MEM during n+2, WB during n+3.
  - fwd_a/fwd_b and stall are combinational from stage registers and current ID inputs, valid in the same cycle.
- Stall lasts exactly one cycle per load-use pair. Next cycle the load is in MEM, EX holds a bubble, and the stall deasserts.
- Simultaneous stall condition and flush: flush wins; stall=0; EX gets a bubble.
- Back-to-back writers of the same register: the younger one (in MEM) is selected.

## Structure
- Shared package `mips_pkg`:
  - Constants FWD_RF=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2, REG_ZERO=5'd0.
  - Stage-record typedef (dst, regwrite, memread, rs, rt).
- One natural sub-module, `fwd_sel`: a combinational comparator producing one SEL_W select from (src, MEM record, WB record). Instantiate it twice, once for fwd_a and once for fwd_b.
- Stage registers, bubble insertion and stall logic stay in the top module.

## Test plan
- Reset mid-stream after issuing `add $3,$1,$2` → stall=0, fwd_a=fwd_b=0 immediately, and no forwarding on the next cycle.
- EX/MEM forwarding: `add $3,$1,$2` then `sub $4,$3,$5` → in the cycle sub is in EX, fwd_a=1, fwd_b=0.
- Priority: `add $3,..`, `or $3,..`, `and $6,$3,$3` → fwd_a=fwd_b=1 while and is in EX. Drop the `or` → fwd_a=fwd_b=2.
- Load-use: `lw $8,0($9)` then `add $10,$8,$1` → stall=1 for one cycle, bubble in EX; next cycle stall=0; when add reaches EX, fwd_a=2.
- $0 and flush:
  - `addi $0,..` then `add $2,$0,$0` → fwd_a=fwd_b=0.
  - `lw $8` followed by a dependent with flush=1 → stall=0, and EX holds a bubble next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS-32 pipeline definitions: forwarding-select encodings and the
// per-stage records that the hazard/forwarding logic tracks.
package mips_pkg;

   localparam int GPR_W = 5;

   localparam logic [1:0]       FWD_RF    = 2'd0;
   localparam logic [1:0]       FWD_EXMEM = 2'd1;
   localparam logic [1:0]       FWD_MEMWB = 2'd2;
   localparam logic [GPR_W-1:0] REG_ZERO  = 5'd0;

   // Full record held in ID/EX; later stages only need the writer fields.
   typedef struct packed {
      logic [GPR_W-1:0] dst;
      logic             regwrite;
      logic             memread;
      logic [GPR_W-1:0] rs;
      logic [GPR_W-1:0] rt;
   } stage_rec_t;

   typedef struct packed {
      logic [GPR_W-1:0] dst;
      logic             regwrite;
   } fwd_rec_t;

   localparam stage_rec_t BUBBLE = '0;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// ID-stage instruction fields and flush in; stall and EX operand mux selects out.
// There is no valid/ready pair: the ID fields are sampled on every rising edge,
// and the only backpressure is stall, which the IF/ID side must honour by
// re-presenting the same instruction on the following cycle.
interface hazard_fwd_unit_if #(
   parameter int REG_W = 5,
   parameter int SEL_W = 2
);
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic [REG_W-1:0] id_dst;
   logic             id_regwrite;
   logic             id_memread;
   logic             flush;
   logic             stall;
   logic [SEL_W-1:0] fwd_a;
   logic [SEL_W-1:0] fwd_b;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_regwrite, id_memread, flush,
      input  stall, fwd_a, fwd_b
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_regwrite, id_memread, flush,
      output stall, fwd_a, fwd_b
   );
endinterface

// File: rtl/hazard_fwd_unit_fwd_sel.sv
// One ALU operand's forwarding select: the MEM writer beats the WB writer,
// and $0 is never forwarded.
module fwd_sel
   import mips_pkg::*;
#(
   parameter int REG_W = 5,
   parameter int SEL_W = 2
) (
   input  logic [REG_W-1:0] src,
   input  fwd_rec_t         mem_rec,
   input  fwd_rec_t         wb_rec,
   output logic [SEL_W-1:0] sel
);

   logic mem_hit;
   logic wb_hit;

   always_comb begin
      mem_hit = mem_rec.regwrite && (mem_rec.dst != REG_ZERO) && (mem_rec.dst == src);
      wb_hit  = wb_rec.regwrite  && (wb_rec.dst  != REG_ZERO) && (wb_rec.dst  == src);
      sel     = FWD_RF;
      if (mem_hit) begin
         sel = FWD_EXMEM;
      end else if (wb_hit) begin
         sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding controller for the 5-stage MIPS-32 pipeline: tracks
// destinations through EX/MEM/WB, drives the ALU operand selects and load-use stall.
module hazard_fwd_unit
   import mips_pkg::*;
#(
   parameter int REG_W = 5,
   parameter int SEL_W = 2
) (
   input logic               clk,
   input logic               reset,
   hazard_fwd_unit_if.slave  bus
);

   stage_rec_t ex_q,  ex_d;
   fwd_rec_t   mem_q, mem_d;
   fwd_rec_t   wb_q,  wb_d;

   logic rs_hit;
   logic rt_hit;
   logic hazard;

   always_comb begin
      rs_hit = bus.id_use_rs && (bus.id_rs == ex_q.dst);
      rt_hit = bus.id_use_rt && (bus.id_rt == ex_q.dst);
      hazard = ex_q.memread && ex_q.regwrite && (ex_q.dst != REG_ZERO) && (rs_hit || rt_hit);
   end

   // A flushed instruction is dead anyway, so it never needs to be held.
   assign bus.stall = hazard && !bus.flush;

   always_comb begin
      ex_d = BUBBLE;
      if (!(hazard || bus.flush)) begin
         ex_d.dst      = bus.id_dst;
         ex_d.regwrite = bus.id_regwrite;
         ex_d.memread  = bus.id_memread;
         ex_d.rs       = bus.id_rs;
         ex_d.rt       = bus.id_rt;
      end
      mem_d.dst      = ex_q.dst;
      mem_d.regwrite = ex_q.regwrite;
      wb_d           = mem_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q  <= BUBBLE;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   fwd_sel #(.REG_W(REG_W), .SEL_W(SEL_W)) u_fwd_a (
      .src     (ex_q.rs),
      .mem_rec (mem_q),
      .wb_rec  (wb_q),
      .sel     (bus.fwd_a)
   );

   fwd_sel #(.REG_W(REG_W), .SEL_W(SEL_W)) u_fwd_b (
      .src     (ex_q.rt),
      .mem_rec (mem_q),
      .wb_rec  (wb_q),
      .sel     (bus.fwd_b)
   );

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: a behavioural pipeline model feeds an expected
// queue each cycle, plus directed checks for the classic hazard sequences.
module tb_hazard_fwd_unit;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_fwd_unit_if #(.REG_W(5), .SEL_W(2)) bus ();

   hazard_fwd_unit #(.REG_W(5), .SEL_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dst;
      logic       rw;
      logic       mr;
   } m_rec_t;

   m_rec_t m_ex, m_mem, m_wb, m_nop;

   logic [4:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] m_sel(input logic [4:0] src);
      if (m_mem.rw && m_mem.dst != 5'd0 && m_mem.dst == src) return 2'd1;
      if (m_wb.rw && m_wb.dst != 5'd0 && m_wb.dst == src) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic m_hazard();
      if (!(m_ex.mr && m_ex.rw && m_ex.dst != 5'd0)) return 1'b0;
      return (bus.id_use_rs && bus.id_rs == m_ex.dst) ||
             (bus.id_use_rt && bus.id_rt == m_ex.dst);
   endfunction

   task automatic model_reset();
      m_nop = '{rs: 5'd0, rt: 5'd0, dst: 5'd0, rw: 1'b0, mr: 1'b0};
      m_ex  = m_nop;
      m_mem = m_nop;
      m_wb  = m_nop;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                        input logic urs, input logic urt, input logic rw, input logic mr,
                        input logic fl);
      logic st;
      bus.id_rs       = rs;
      bus.id_rt       = rt;
      bus.id_dst      = dst;
      bus.id_use_rs   = urs;
      bus.id_use_rt   = urt;
      bus.id_regwrite = rw;
      bus.id_memread  = mr;
      bus.flush       = fl;
      st = m_hazard() && !fl;
      exp_q.push_back({st, m_sel(m_ex.rs), m_sel(m_ex.rt)});
   endtask

   task automatic sample();
      logic [4:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq("sb_stall", {7'd0, bus.stall}, {7'd0, e[4]});
      check_eq("sb_fwd_a", {6'd0, bus.fwd_a}, {6'd0, e[3:2]});
      check_eq("sb_fwd_b", {6'd0, bus.fwd_b}, {6'd0, e[1:0]});
   endtask

   task automatic advance();
      logic kill;
      @(posedge clk);
      kill = m_hazard() || bus.flush;
      if (reset) begin
         model_reset();
      end else begin
         m_wb  = m_mem;
         m_mem = m_ex;
         if (kill) m_ex = m_nop;
         else m_ex = '{rs: bus.id_rs, rt: bus.id_rt, dst: bus.id_dst,
                       rw: bus.id_regwrite, mr: bus.id_memread};
      end
      #1;
   endtask

   task automatic r_op(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic fl);
      drive(rs, rt, dst, 1'b1, 1'b1, 1'b1, 1'b0, fl);
   endtask

   task automatic lw_op(input logic [4:0] dst, input logic [4:0] base);
      drive(base, dst, dst, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic nop_op();
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic nop_step();
      nop_op(); sample(); advance();
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) nop_step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      reset = 1'b1;
      nop_op();
      void'(exp_q.pop_front());
      #1;
      check_eq("rst_stall", {7'd0, bus.stall}, 8'd0);
      check_eq("rst_fwd_a", {6'd0, bus.fwd_a}, 8'd0);
      check_eq("rst_fwd_b", {6'd0, bus.fwd_b}, 8'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // EX/MEM forwarding: add $3,$1,$2 ; sub $4,$3,$5
      r_op(5'd3, 5'd1, 5'd2, 1'b0); sample(); advance();
      r_op(5'd4, 5'd3, 5'd5, 1'b0); sample(); advance();
      nop_op(); sample();
      check_eq("exmem_fwd_a", {6'd0, bus.fwd_a}, 8'd1);
      check_eq("exmem_fwd_b", {6'd0, bus.fwd_b}, 8'd0);
      advance();
      drain();

      // Priority: add $3 ; or $3 ; and $6,$3,$3
      r_op(5'd3, 5'd1, 5'd2, 1'b0); sample(); advance();
      r_op(5'd3, 5'd4, 5'd5, 1'b0); sample(); advance();
      r_op(5'd6, 5'd3, 5'd3, 1'b0); sample(); advance();
      nop_op(); sample();
      check_eq("prio_fwd_a", {6'd0, bus.fwd_a}, 8'd1);
      check_eq("prio_fwd_b", {6'd0, bus.fwd_b}, 8'd1);
      advance();
      drain();

      // Same, without the younger writer: result comes from MEM/WB
      r_op(5'd3, 5'd1, 5'd2, 1'b0); sample(); advance();
      nop_step();
      r_op(5'd6, 5'd3, 5'd3, 1'b0); sample(); advance();
      nop_op(); sample();
      check_eq("memwb_fwd_a", {6'd0, bus.fwd_a}, 8'd2);
      check_eq("memwb_fwd_b", {6'd0, bus.fwd_b}, 8'd2);
      advance();
      drain();

      // Load-use: lw $8,0($9) ; add $10,$8,$1 (re-presented after the stall)
      lw_op(5'd8, 5'd9); sample(); advance();
      r_op(5'd10, 5'd8, 5'd1, 1'b0); sample();
      check_eq("lu_stall", {7'd0, bus.stall}, 8'd1);
      advance();
      r_op(5'd10, 5'd8, 5'd1, 1'b0); sample();
      check_eq("lu_stall_drop", {7'd0, bus.stall}, 8'd0);
      check_eq("lu_bubble_a", {6'd0, bus.fwd_a}, 8'd0);
      advance();
      nop_op(); sample();
      check_eq("lu_fwd_a", {6'd0, bus.fwd_a}, 8'd2);
      check_eq("lu_fwd_b", {6'd0, bus.fwd_b}, 8'd0);
      advance();
      drain();

      // $0 is never forwarded: addi $0,$1,.. ; add $2,$0,$0
      drive(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); sample(); advance();
      r_op(5'd2, 5'd0, 5'd0, 1'b0); sample(); advance();
      nop_op(); sample();
      check_eq("zero_fwd_a", {6'd0, bus.fwd_a}, 8'd0);
      check_eq("zero_fwd_b", {6'd0, bus.fwd_b}, 8'd0);
      advance();
      drain();

      // Flush beats stall: lw $8 ; add $10,$8,$8 flushed ; or $11,$10,$10
      lw_op(5'd8, 5'd9); sample(); advance();
      r_op(5'd10, 5'd8, 5'd8, 1'b1); sample();
      check_eq("fl_stall", {7'd0, bus.stall}, 8'd0);
      advance();
      r_op(5'd11, 5'd10, 5'd10, 1'b0); sample(); advance();
      nop_op(); sample();
      check_eq("fl_bubble_a", {6'd0, bus.fwd_a}, 8'd0);
      check_eq("fl_bubble_b", {6'd0, bus.fwd_b}, 8'd0);
      advance();
      drain();

      // Reset mid-stream while forwarding is active
      r_op(5'd3, 5'd1, 5'd2, 1'b0); sample(); advance();
      r_op(5'd4, 5'd3, 5'd5, 1'b0); sample(); advance();
      nop_op(); sample();
      #1 reset = 1'b1;
      #1;
      check_eq("mrst_fwd_a", {6'd0, bus.fwd_a}, 8'd0);
      check_eq("mrst_stall", {7'd0, bus.stall}, 8'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      r_op(5'd4, 5'd3, 5'd5, 1'b0); sample(); advance();
      nop_op(); sample();
      check_eq("mrst_no_stale", {6'd0, bus.fwd_a}, 8'd0);
      advance();

      // Reset while a load-use stall is asserted
      lw_op(5'd8, 5'd9); sample(); advance();
      r_op(5'd10, 5'd8, 5'd1, 1'b0); sample();
      #1 reset = 1'b1;
      #1;
      check_eq("mrst_lu_stall", {7'd0, bus.stall}, 8'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      drain();

      // Random traffic over a small register set to force collisions
      for (int i = 0; i < 400; i++) begin
         logic [4:0] rs, rt, dst;
         logic       urs, urt, rw, mr, fl;
         rs  = 5'($urandom_range(0, 3));
         rt  = 5'($urandom_range(0, 3));
         dst = 5'($urandom_range(0, 3));
         urs = 1'($urandom_range(0, 1));
         urt = 1'($urandom_range(0, 1));
         rw  = ($urandom_range(0, 3) != 0);
         mr  = rw && ($urandom_range(0, 2) == 0);
         fl  = ($urandom_range(0, 7) == 0);
         drive(rs, rt, dst, urs, urt, rw, mr, fl);
         sample();
         advance();
      end

      check_eq("sb_empty", 8'(exp_q.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
